// File: rtl/wm_seq.sv
// wm_seq: washing-machine cycle sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   start/stop/pause_tog: single-cycle command pulses
//   cfg_*               : run configuration, snapshotted when a run starts
//   valve_hot/valve_cold/motor_wash/motor_spin/drain_pump : actuator enables
//   busy/paused/done    : run status (done is a one-cycle completion pulse)
//   phase/remain/rinse_cnt : state code, ticks left in phase, rinses completed
// Every output is a register or a decode of registers only.
module wm_seq #(
  parameter int TICK_DIV   = 125_000_000,
  parameter int DRAIN_TIME = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause_tog,
  input  logic [7:0] cfg_time_wash,
  input  logic [7:0] cfg_time_rinse,
  input  logic [7:0] cfg_time_dry,
  input  logic [7:0] cfg_repeat,
  input  logic [1:0] cfg_water_height,
  input  logic [1:0] cfg_hot_cold,
  output logic       valve_hot,
  output logic       valve_cold,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       drain_pump,
  output logic       busy,
  output logic       paused,
  output logic       done,
  output logic [2:0] phase,
  output logic [7:0] remain,
  output logic [7:0] rinse_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0, S_FILL = 3'd1, S_WASH = 3'd2, S_DRAIN = 3'd3,
    S_RINSE = 3'd4, S_DRY  = 3'd5, S_DONE = 3'd6, S_ABORT = 3'd7
  } state_t;

  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]     DRAIN_DUR = 8'(DRAIN_TIME);

  state_t        state, state_n;
  logic [PW-1:0] presc;
  logic [7:0]    remain_r, rinse_r, dur_n;
  logic          paused_r, wash_done;
  logic [7:0]    snap_wash, snap_rinse, snap_dry, snap_rep;
  logic [1:0]    snap_height, snap_hc;
  logic [7:0]    rep_san;
  logic [1:0]    h_san, hc_san, fill_h;
  logic          tick, run, act;

  function automatic logic is_busy(state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

  assign rep_san = (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
  assign h_san   = (cfg_water_height == 2'd3) ? 2'd2 : cfg_water_height;
  assign hc_san  = (cfg_hot_cold == 2'd3) ? 2'd0 : cfg_hot_cold;

  assign run  = is_busy(state) && !paused_r;
  assign tick = (presc == PRESC_MAX);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_FILL;
      S_DONE: state_n = S_IDLE;
      default: begin
        if (stop && state != S_ABORT) state_n = S_ABORT;
        else if (!paused_r && remain_r == 8'd0) begin
          case (state)
            S_FILL:  state_n = wash_done ? S_RINSE : S_WASH;
            S_WASH:  state_n = S_DRAIN;
            S_DRAIN: state_n = (rinse_r < snap_rep) ? S_FILL : S_DRY;
            S_RINSE: state_n = S_DRAIN;
            S_DRY:   state_n = S_DONE;
            default: state_n = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // The first FILL is entered in the same edge as the snapshot, so its
  // duration comes straight from the sanitised input.
  assign fill_h = (state == S_IDLE) ? h_san : snap_height;

  always_comb begin
    dur_n = 8'd0;
    case (state_n)
      S_FILL:           dur_n = {6'd0, fill_h} + 8'd2;
      S_WASH:           dur_n = snap_wash;
      S_RINSE:          dur_n = snap_rinse;
      S_DRY:            dur_n = snap_dry;
      S_DRAIN, S_ABORT: dur_n = DRAIN_DUR;
      default:          dur_n = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      presc       <= '0;
      remain_r    <= 8'd0;
      rinse_r     <= 8'd0;
      paused_r    <= 1'b0;
      wash_done   <= 1'b0;
      snap_wash   <= 8'd0;
      snap_rinse  <= 8'd0;
      snap_dry    <= 8'd0;
      snap_rep    <= 8'd0;
      snap_height <= 2'd0;
      snap_hc     <= 2'd0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        remain_r <= dur_n;
        presc    <= '0;
      end else if (run) begin
        if (tick) begin
          presc <= '0;
          if (remain_r != 8'd0) remain_r <= remain_r - 8'd1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      // stop clears pause; leaving the busy states never carries it along
      if (!is_busy(state_n) || (state_n == S_ABORT && state != S_ABORT))
        paused_r <= 1'b0;
      else if (is_busy(state) && pause_tog)
        paused_r <= ~paused_r;
      if (state == S_IDLE && start) begin
        snap_wash   <= cfg_time_wash;
        snap_rinse  <= cfg_time_rinse;
        snap_dry    <= cfg_time_dry;
        snap_rep    <= rep_san;
        snap_height <= h_san;
        snap_hc     <= hc_san;
        rinse_r     <= 8'd0;
        wash_done   <= 1'b0;
      end
      if (state == S_WASH && state_n == S_DRAIN) wash_done <= 1'b1;
      if (state == S_RINSE && state_n == S_DRAIN) rinse_r <= rinse_r + 8'd1;
    end
  end

  assign act        = !paused_r;
  // hot_cold: 0 both, 1 cold only, 2 hot only; rinse fills are always cold
  assign valve_hot  = act && state == S_FILL && !wash_done && snap_hc != 2'd1;
  assign valve_cold = act && state == S_FILL && (wash_done || snap_hc != 2'd2);
  assign motor_wash = act && (state == S_WASH || state == S_RINSE);
  assign drain_pump = act && (state == S_DRAIN || state == S_ABORT);
  assign motor_spin = act && state == S_DRY;
  assign busy       = is_busy(state);
  assign paused     = paused_r;
  assign done       = (state == S_DONE);
  assign phase      = state;
  assign remain     = remain_r;
  assign rinse_cnt  = rinse_r;

endmodule
